int_ctrl: RTL
=============

INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 6, number of interrupt sources mapped onto the CPU hardware-interrupt lines.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on each irq_src bit.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port dev_addr  input  2  register select from the bridge, bits [3:2].
REQ-006 SHALL have port dev_wd  input  32  write data from the bridge.
REQ-007 SHALL have port we_intc  input  1  register write strobe from the bridge.
REQ-008 SHALL have port dev_rd  output  32  read data to the bridge.
REQ-009 SHALL have port irq_src  input  NUM_SRC  device interrupt lines, bit 0 = timer.
REQ-010 SHALL have port int_ack  input  1  one-cycle pulse, CPU has taken the interrupt.
REQ-011 SHALL have port int_eoi  input  1  one-cycle pulse, CPU executed eret.
REQ-012 SHALL have port HWInt  output  NUM_SRC  one-hot request to the CPU, bit i = source i.

Function
REQ-013 SHALL decode dev_addr: 0 MASK (rw, bits [NUM_SRC-1:0]); 1 PEND (read; write-1-to-clear); 2 ISR (read: bit31 in-service valid, bits [2:0] source id); 3 CTRL (rw, bit0 GIE).
REQ-014 SHALL return dev_rd combinationally from dev_addr, zero-extended, with unused bits 0.
REQ-015 SHALL run FSM IDLE -> REQ -> SERVICE -> IDLE.
REQ-016 IDLE: when GIE=1 and (PEND & MASK) != 0, SHALL latch the lowest-index such source as req_id, go to REQ and register HWInt = one-hot(req_id) in the same edge.
REQ-017 REQ: HWInt SHALL hold stable until int_ack; on int_ack, ISR gets {valid=1, req_id}, HWInt = 0, and the FSM moves to SERVICE.
REQ-018 REQ: if PEND[req_id] & MASK[req_id] & GIE falls to 0 before int_ack, SHALL drop HWInt and return to IDLE the next cycle; a higher-priority arrival SHALL NOT replace req_id.
REQ-019 SERVICE: no new request is raised (no nesting); int_eoi SHALL clear ISR valid and return to IDLE.
REQ-020 int_ack outside REQ and int_eoi outside SERVICE SHALL be ignored.
REQ-021 A same-cycle set and clear of a PEND bit (edge, W1C or ack) SHALL resolve as set.
REQ-022 Latency: irq_src rises before edge N; PEND visible after edge N+SYNC_STAGES+1; HWInt after the following edge.

Reset
REQ-023 With rst low: MASK=0, PEND=0, ISR=0, GIE=0, HWInt=0, synchronizers=0, FSM=IDLE, immediately and independent of clk.
REQ-024 Reset mid-REQ or mid-SERVICE SHALL abandon the transaction with no residual pending or in-service state.

Configuration
REQ-025 With INTC_EDGE_EN defined: PEND[i] SHALL set on a synchronized rising edge of irq_src[i] and clear on int_ack for that source or a W1C write.
REQ-026 Without INTC_EDGE_EN: PEND SHALL mirror the synchronized irq_src level, and writes to PEND and int_ack SHALL NOT alter it.

Structure
REQ-027 Package intc_pkg SHALL hold the register offsets, the FSM state enum, the CTRL bit positions and the NUM_SRC default.
REQ-028 Sub-module intc_sync SHALL implement the per-bit SYNC_STAGES synchronizer plus rising-edge detect, one instance per source.

Verification
REQ-029 Write MASK=0x01 and CTRL=0x1, pulse irq_src[0] -> HWInt=6'b000001 within SYNC_STAGES+2 cycles; int_ack -> HWInt=0 and ISR=0x80000000.
REQ-030 Raise irq_src[3] and irq_src[1] in the same cycle with MASK=0x3F and GIE=1 -> HWInt=6'b000010; after ack and eoi -> HWInt=6'b001000.
REQ-031 In REQ for source 2, write MASK=0 -> HWInt=0 next cycle, FSM IDLE, PEND[2] still 1.
REQ-032 In SERVICE, raise irq_src[0] -> HWInt stays 0 until int_eoi, then HWInt=6'b000001.
REQ-033 Edge build: write PEND=0x04 in the same cycle as the source-2 edge -> PEND[2]=1; level build: PEND follows irq_src and ignores W1C.
REQ-034 Assert rst low during SERVICE -> all registers and HWInt read 0 with no clk edge; int_eoi after release has no effect.

Source files
------------

// File: rtl/intc_pkg.sv
// intc_pkg: register map, CTRL/ISR bit positions, FSM states and defaults
// shared by the interrupt controller files.
package intc_pkg;

  localparam int NUM_SRC_DEF = 6;   // default number of interrupt sources
  localparam int ID_W        = 3;   // width of the source id held in ISR

  // Register offsets, addressed by dev_addr (bus address bits [3:2])
  localparam logic [1:0] REG_MASK = 2'd0;
  localparam logic [1:0] REG_PEND = 2'd1;
  localparam logic [1:0] REG_ISR  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  // Bit positions inside CTRL and ISR
  localparam int CTRL_GIE = 0;
  localparam int ISR_VLD  = 31;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

endpackage

// File: rtl/intc_sync.sv
// intc_sync: SYNC_STAGES-deep synchronizer for one interrupt line, followed
// by one register stage that gives a registered level and a registered
// one-cycle rising-edge pulse.
module intc_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level;
  logic                   r_rise;

  // Synchronizer chain, stage 0 samples the asynchronous line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= i_async;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // Registered level and rising edge of the synchronized line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_level <= r_sync[SYNC_STAGES-1];
      r_rise  <= r_sync[SYNC_STAGES-1] & ~r_level;
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: interrupt controller between device IRQ lines and the CPU
// hardware-interrupt inputs. Registers MASK/PEND/ISR/CTRL on a small bus,
// fixed lowest-index-first priority, single outstanding request, no nesting.
// Build option: INTC_EDGE_EN makes PEND edge-latched with W1C/ack clear;
// without it PEND mirrors the synchronized source level.
module int_ctrl
  import intc_pkg::*;
#(
  parameter int NUM_SRC     = NUM_SRC_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         dev_addr,
  input  logic [31:0]        dev_wd,
  input  logic               we_intc,
  output logic [31:0]        dev_rd,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               int_ack,
  input  logic               int_eoi,
  output logic [NUM_SRC-1:0] HWInt
);

  localparam logic [NUM_SRC-1:0] ONE = NUM_SRC'(1);

  logic [NUM_SRC-1:0] w_level;
  logic [NUM_SRC-1:0] w_rise;

  logic [NUM_SRC-1:0] r_mask;
  logic [NUM_SRC-1:0] r_pend;
  logic               r_gie;
  logic               r_isr_vld;
  logic [ID_W-1:0]    r_isr_id;
  logic [ID_W-1:0]    r_req_id;
  logic [NUM_SRC-1:0] r_hwint;
  state_e             r_state;

  logic [NUM_SRC-1:0] w_pend_nxt;
  logic [NUM_SRC-1:0] w_active;
  logic [NUM_SRC-1:0] w_req_oh;
  logic               w_req_live;
  logic [ID_W-1:0]    w_low_id;
  logic               w_wr_mask;
  logic               w_wr_pend;
  logic               w_wr_ctrl;
  logic               w_ack_take;

  state_e             w_state_nxt;
  logic [ID_W-1:0]    w_req_id_nxt;
  logic [NUM_SRC-1:0] w_hwint_nxt;
  logic               w_isr_vld_nxt;
  logic [ID_W-1:0]    w_isr_id_nxt;
  logic               w_unused;

  intc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync [NUM_SRC-1:0] (
    .clk     (clk),
    .rst     (rst),
    .i_async (irq_src),
    .o_level (w_level),
    .o_rise  (w_rise)
  );

  assign w_wr_mask  = we_intc && (dev_addr == REG_MASK);
  assign w_wr_pend  = we_intc && (dev_addr == REG_PEND);
  assign w_wr_ctrl  = we_intc && (dev_addr == REG_CTRL);
  assign w_ack_take = (r_state == ST_REQ) && int_ack;
  assign w_active   = r_pend & r_mask & {NUM_SRC{r_gie}};
  assign w_req_oh   = ONE << r_req_id;
  assign w_req_live = |(w_active & w_req_oh);

  // Only one of w_level / w_rise feeds PEND in a given build
  assign w_unused = ^{dev_wd[31:NUM_SRC], w_level, w_rise, w_wr_pend};

  // PEND next value: set wins over any same-cycle clear
  always_comb begin
`ifdef INTC_EDGE_EN
    logic [NUM_SRC-1:0] clr;
    clr = '0;
    if (w_wr_pend)  clr = clr | dev_wd[NUM_SRC-1:0];
    if (w_ack_take) clr = clr | w_req_oh;
    w_pend_nxt = (r_pend & ~clr) | w_rise;
`else
    w_pend_nxt = w_level;
`endif
  end

  // Lowest-index enabled pending source
  always_comb begin
    w_low_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (w_active[i]) w_low_id = ID_W'(i);
  end

  // Bus-visible configuration and pending registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mask <= '0;
      r_gie  <= 1'b0;
      r_pend <= '0;
    end else begin
      if (w_wr_mask) r_mask <= dev_wd[NUM_SRC-1:0];
      if (w_wr_ctrl) r_gie  <= dev_wd[CTRL_GIE];
      r_pend <= w_pend_nxt;
    end
  end

  // FSM state and the registers it owns (HWInt, req_id, ISR)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_req_id  <= '0;
      r_hwint   <= '0;
      r_isr_vld <= 1'b0;
      r_isr_id  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_req_id  <= w_req_id_nxt;
      r_hwint   <= w_hwint_nxt;
      r_isr_vld <= w_isr_vld_nxt;
      r_isr_id  <= w_isr_id_nxt;
    end
  end

  // FSM next state: arbitrate in IDLE, hold/drop in REQ, wait eoi in SERVICE.
  // An ack arriving in REQ is honoured even if the source drops that cycle,
  // since HWInt was still asserted when the CPU took it.
  always_comb begin
    w_state_nxt   = r_state;
    w_req_id_nxt  = r_req_id;
    w_hwint_nxt   = r_hwint;
    w_isr_vld_nxt = r_isr_vld;
    w_isr_id_nxt  = r_isr_id;
    case (r_state)
      ST_IDLE: begin
        w_hwint_nxt = '0;
        if (|w_active) begin
          w_state_nxt  = ST_REQ;
          w_req_id_nxt = w_low_id;
          w_hwint_nxt  = ONE << w_low_id;
        end
      end
      ST_REQ: begin
        if (int_ack) begin
          w_state_nxt   = ST_SERVICE;
          w_hwint_nxt   = '0;
          w_isr_vld_nxt = 1'b1;
          w_isr_id_nxt  = r_req_id;
        end else if (!w_req_live) begin
          w_state_nxt = ST_IDLE;
          w_hwint_nxt = '0;
        end
      end
      ST_SERVICE: begin
        w_hwint_nxt = '0;
        if (int_eoi) begin
          w_state_nxt   = ST_IDLE;
          w_isr_vld_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_hwint_nxt = '0;
      end
    endcase
  end

  // Read mux, zero-extended
  always_comb begin
    dev_rd = '0;
    case (dev_addr)
      REG_MASK: dev_rd[NUM_SRC-1:0] = r_mask;
      REG_PEND: dev_rd[NUM_SRC-1:0] = r_pend;
      REG_ISR: begin
        dev_rd[ISR_VLD]  = r_isr_vld;
        dev_rd[ID_W-1:0] = r_isr_id;
      end
      default:  dev_rd[CTRL_GIE] = r_gie;
    endcase
  end

  assign HWInt = r_hwint;

endmodule
